pool_relu_2x2: RTL and testbench
================================

// Module: pool_relu_2x2
// PURPOSE
//   Downstream stage of conv: consumes the 6-channel signed conv feature stream
//   (one pixel per valid cycle, raster order), applies 2x2 stride-2 max pooling
//   per channel, then optional ReLU. Emits one pooled pixel (all channels) per window.
//   No backpressure: conv has no ready input, so every valid beat is accepted.
// PARAMETERS
//   IN_WIDTH  28  columns per input feature map (must be even; elaboration $error otherwise)
//   IN_HEIGHT 28  rows per input feature map (must be even; elaboration $error otherwise)
//   NUM_CH    6   feature maps processed in parallel
//   DATA_W    16  signed sample width, input and output
//   RELU_EN   1   1: clamp negative pooled values to 0; 0: pass pooled max unchanged
// PORTS
//   i_clk            in   1               clock, all logic on rising edge
//   i_rst_n          in   1               async active-low reset
//   i_feature_valid  in   1               input pixel valid (conv o_feature_valid)
//   i_features       in   DATA_W x NUM_CH signed input pixel, unpacked [0:NUM_CH-1]
//   i_last_feature   in   1               final pixel of input frame (conv o_last_feature)
//   o_pool_valid     out  1               pooled pixel valid, single-cycle pulse
//   o_pooled         out  DATA_W x NUM_CH signed pooled pixel, unpacked [0:NUM_CH-1]
//   o_last_pooled    out  1               high with the final pooled pixel of a frame
//   o_sync_err       out  1               1-cycle pulse: i_last_feature at wrong position
//   o_dbg_col        out  clog2(IN_WIDTH)  current input column counter
//   o_dbg_row        out  clog2(IN_HEIGHT) current input row counter
// BEHAVIOUR
//   Reset: all outputs 0; col/row = 0; FSM = ROW_STORE; hold regs 0. Line buffer
//     (IN_WIDTH/2 x NUM_CH x DATA_W) not reset; always written before read.
//   Counters advance only on i_feature_valid; col wraps IN_WIDTH-1 -> 0 and bumps row;
//     row wraps IN_HEIGHT-1 -> 0. Invalid cycles change no state.
//   FSM (row phase): ROW_STORE (even row) -> ROW_POOL on col wrap; ROW_POOL -> ROW_STORE
//     on col wrap. Also -> ROW_STORE on frame end or i_last_feature.
//   Even col: hold[c] <= i_features[c]. Odd col: hmax[c] = signed max(hold[c], in[c]).
//   ROW_STORE, odd col: lb[col>>1][c] <= hmax[c].
//   ROW_POOL, odd col: p = signed max(lb[col>>1][c], hmax[c]); ReLU if RELU_EN;
//     registered to o_pooled, o_pool_valid = 1 on the next cycle (latency 1 clk).
//   o_pooled holds last value between pulses; o_pool_valid low otherwise.
//   Ties: equal values give that value; comparison strictly signed (-32768 is minimum).
//   Output count: (IN_WIDTH/2)*(IN_HEIGHT/2) pulses per frame (196 default).
//   o_last_pooled: asserted with the pulse from input (IN_HEIGHT-1, IN_WIDTH-1).
//   i_last_feature at (IN_HEIGHT-1, IN_WIDTH-1): normal; counters wrap to 0.
//   i_last_feature elsewhere: that beat still processed if it completes a window, but
//     o_last_pooled not raised; counters -> 0, FSM -> ROW_STORE, o_sync_err pulses 1 clk
//     after; partial windows discarded.
//   Frame end reached without i_last_feature: counters wrap normally, no error.
//   i_rst_n asserted mid-frame: outputs/counters clear immediately (async); next frame
//     after release processes from (0,0) with no stale output.
// TESTING
//   1 Reset: hold i_rst_n=0 20ns, drive valid data -> o_pool_valid=0, o_pooled all 0.
//   2 Ramp: all ch = row*28+col, valid every cycle -> 196 pulses, pulse k(r,c) =
//     (2r+1)*28+2c+1, first = 29 one clk after input (1,1); o_last_pooled on 196th = 783.
//   3 ReLU: all inputs -5 -> outputs 0 (RELU_EN=1); -5 with RELU_EN=0.
//   4 Signed extremes per ch: window {-32768,32767,0,-1} -> 32767; window all -32768,
//     RELU_EN=0 -> -32768; ch0..5 distinct patterns -> no channel cross-talk.
//   5 Valid gaps: ramp of test 2 with random i_feature_valid deassertion -> identical
//     196-value sequence, each pulse 1 clk after its completing input beat.
//   6 i_last_feature at (3,10) -> o_sync_err 1 pulse, no o_last_pooled; next full ramp
//     frame correct; i_rst_n low at (5,7) -> immediate clear, following frame correct.

Source files
------------

// File: rtl/pool_relu_2x2.sv
// -----------------------------------------------------------------------------
// pool_relu_2x2
//   2x2 stride-2 max pooling over a raster-ordered, multi-channel signed feature
//   stream, followed by an optional ReLU. One pooled pixel (all channels) is
//   emitted per 2x2 window, one clock after the input beat that completes it.
//
// Handshake: i_feature_valid qualifies a beat. There is no ready signal; every
//   valid beat is consumed. o_pool_valid is a one-cycle pulse that qualifies
//   o_pooled / o_last_pooled; o_pooled holds its last value between pulses.
//
// Ports
//   i_clk, i_rst_n    clock (rising edge), asynchronous active-low reset
//   i_feature_valid   input pixel valid
//   i_features        signed input pixel, one sample per channel
//   i_last_feature    final pixel of the input frame
//   o_pool_valid      pooled pixel valid pulse
//   o_pooled          signed pooled pixel, one sample per channel
//   o_last_pooled     marks the final pooled pixel of a frame
//   o_sync_err        pulse: i_last_feature seen away from the frame's last pixel
//   o_dbg_col/row     current input column/row counters
//   o_dbg_state       row-phase FSM state (0 = ROW_STORE, 1 = ROW_POOL)
// -----------------------------------------------------------------------------
module pool_relu_2x2 #(
  parameter int IN_WIDTH  = 28,
  parameter int IN_HEIGHT = 28,
  parameter int NUM_CH    = 6,
  parameter int DATA_W    = 16,
  parameter int RELU_EN   = 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_feature_valid,
  input  logic signed [DATA_W-1:0]      i_features [0:NUM_CH-1],
  input  logic                          i_last_feature,
  output logic                          o_pool_valid,
  output logic signed [DATA_W-1:0]      o_pooled [0:NUM_CH-1],
  output logic                          o_last_pooled,
  output logic                          o_sync_err,
  output logic [$clog2(IN_WIDTH)-1:0]   o_dbg_col,
  output logic [$clog2(IN_HEIGHT)-1:0]  o_dbg_row,
  output logic                          o_dbg_state
);

  localparam int COL_W = $clog2(IN_WIDTH);
  localparam int ROW_W = $clog2(IN_HEIGHT);
  localparam int LB_D  = IN_WIDTH / 2;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_HEIGHT - 1);

  if ((IN_WIDTH % 2) != 0) begin : g_bad_width
    $error("pool_relu_2x2: IN_WIDTH must be even");
  end
  if ((IN_HEIGHT % 2) != 0) begin : g_bad_height
    $error("pool_relu_2x2: IN_HEIGHT must be even");
  end

  typedef enum logic {
    ROW_STORE = 1'b0,  // even row: pair-max written to the line buffer
    ROW_POOL  = 1'b1   // odd row: pair-max combined with the line buffer
  } state_e;

  state_e                    state_q, state_d;
  logic [COL_W-1:0]          col_q, col_d;
  logic [ROW_W-1:0]          row_q, row_d;
  logic signed [DATA_W-1:0]  hold_q   [0:NUM_CH-1];
  logic signed [DATA_W-1:0]  pooled_q [0:NUM_CH-1];
  logic                      valid_q, last_q, err_q;

  // Line buffer: one horizontal pair-max per window column. Not reset, since
  // each entry is always written in the even row before the odd row reads it.
  logic signed [DATA_W-1:0]  lb_q [0:LB_D-1][0:NUM_CH-1];

  logic                      at_col_end, at_frame_end, sync_bad, window_done, lb_wr;
  logic [COL_W-2:0]          lb_idx;
  logic signed [DATA_W-1:0]  hmax   [0:NUM_CH-1];
  logic signed [DATA_W-1:0]  pool_d [0:NUM_CH-1];

  always_comb begin
    at_col_end   = (col_q == COL_LAST);
    at_frame_end = at_col_end && (row_q == ROW_LAST);
    sync_bad     = i_feature_valid && i_last_feature && !at_frame_end;
    window_done  = i_feature_valid && (state_q == ROW_POOL) && col_q[0];
    lb_wr        = i_feature_valid && (state_q == ROW_STORE) && col_q[0];
    lb_idx       = col_q[COL_W-1:1];

    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    if (i_feature_valid) begin
      if (sync_bad) begin
        // Misplaced frame end: abandon the frame and restart at (0,0).
        col_d   = '0;
        row_d   = '0;
        state_d = ROW_STORE;
      end else if (at_col_end) begin
        col_d   = '0;
        row_d   = at_frame_end ? '0 : row_q + 1'b1;
        state_d = (at_frame_end || state_q == ROW_POOL) ? ROW_STORE : ROW_POOL;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      hmax[c]   = (i_features[c] > hold_q[c]) ? i_features[c] : hold_q[c];
      pool_d[c] = (lb_q[lb_idx][c] > hmax[c]) ? lb_q[lb_idx][c] : hmax[c];
      if ((RELU_EN != 0) && (pool_d[c] < 0)) begin
        pool_d[c] = '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ROW_STORE;
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        hold_q[c]   <= '0;
        pooled_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= window_done;
      last_q  <= window_done && at_frame_end;
      err_q   <= sync_bad;
      for (int c = 0; c < NUM_CH; c++) begin
        if (i_feature_valid && !col_q[0]) begin
          hold_q[c] <= i_features[c];
        end
        if (window_done) begin
          pooled_q[c] <= pool_d[c];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (lb_wr) begin
      for (int c = 0; c < NUM_CH; c++) begin
        lb_q[lb_idx][c] <= hmax[c];
      end
    end
  end

  assign o_pool_valid  = valid_q;
  assign o_pooled      = pooled_q;
  assign o_last_pooled = last_q;
  assign o_sync_err    = err_q;
  assign o_dbg_col     = col_q;
  assign o_dbg_row     = row_q;
  assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_pool_relu_2x2.sv
module tb_pool_relu_2x2;

  localparam int W   = 28;
  localparam int H   = 28;
  localparam int NCH = 6;
  localparam int DW  = 16;

  localparam int M_RAMP = 0;
  localparam int M_NEG5 = 1;
  localparam int M_EXT  = 2;

  typedef logic [NCH-1:0][DW-1:0] vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic                 fv;
  logic                 flast;
  logic signed [DW-1:0] feat [0:NCH-1];
  int                   tb_r, tb_c;

  logic                  v_r, v_n, last_r, last_n, err_r, err_n, st_r, st_n;
  logic signed [DW-1:0]  pooled_r [0:NCH-1];
  logic signed [DW-1:0]  pooled_n [0:NCH-1];
  logic [$clog2(W)-1:0]  dcol_r, dcol_n;
  logic [$clog2(H)-1:0]  drow_r, drow_n;

  pool_relu_2x2 #(.IN_WIDTH(W), .IN_HEIGHT(H), .NUM_CH(NCH), .DATA_W(DW), .RELU_EN(1)) dut_relu (
    .i_clk(clk), .i_rst_n(rst_n), .i_feature_valid(fv), .i_features(feat),
    .i_last_feature(flast), .o_pool_valid(v_r), .o_pooled(pooled_r),
    .o_last_pooled(last_r), .o_sync_err(err_r), .o_dbg_col(dcol_r),
    .o_dbg_row(drow_r), .o_dbg_state(st_r)
  );

  pool_relu_2x2 #(.IN_WIDTH(W), .IN_HEIGHT(H), .NUM_CH(NCH), .DATA_W(DW), .RELU_EN(0)) dut_raw (
    .i_clk(clk), .i_rst_n(rst_n), .i_feature_valid(fv), .i_features(feat),
    .i_last_feature(flast), .o_pool_valid(v_n), .o_pooled(pooled_n),
    .o_last_pooled(last_n), .o_sync_err(err_n), .o_dbg_col(dcol_n),
    .o_dbg_row(drow_n), .o_dbg_state(st_n)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic signed [DW-1:0] relu(input logic signed [DW-1:0] a);
    return (a < 0) ? '0 : a;
  endfunction

  // Stimulus pixel generator.
  function automatic logic signed [DW-1:0] pix_val(input int mode, input int r,
                                                   input int c, input int ch);
    int q;
    int v;
    q = (r % 2) * 2 + (c % 2);
    v = 0;
    case (mode)
      M_RAMP: v = r * W + c;
      M_NEG5: v = -5;
      default: begin
        case (ch)
          0: v = (q == 0) ? -32768 : (q == 1) ? 32767 : (q == 2) ? 0 : -1;
          1: v = -32768;
          2: v = -(r * W + c);
          3: v = r * c - 300;
          4: v = ((r + c) % 3 == 0) ? -7 : 3;
          default: v = 16384 - r * c * 40 - c;
        endcase
      end
    endcase
    return DW'(v);
  endfunction

  // ---------------- reference model ----------------
  // Keeps the whole input frame as driven; a window result is the max of the
  // four stored pixels whenever the bottom-right pixel of a 2x2 block arrives.
  logic signed [DW-1:0] pix_mem [0:H-1][0:W-1][0:NCH-1];
  vec_t exp_q[$];
  vec_t model_log[$];
  logic exp_valid = 1'b0;
  logic exp_last  = 1'b0;
  logic exp_err   = 1'b0;

  function automatic vec_t window_max(input int r, input int c);
    vec_t v;
    for (int ch = 0; ch < NCH; ch++) begin
      v[ch] = smax(smax(pix_mem[r-1][c-1][ch], pix_mem[r-1][c][ch]),
                   smax(pix_mem[r][c-1][ch], feat[ch]));
    end
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_valid <= 1'b0;
      exp_last  <= 1'b0;
      exp_err   <= 1'b0;
      exp_q.delete();
    end else begin
      exp_valid <= 1'b0;
      exp_last  <= 1'b0;
      exp_err   <= 1'b0;
      if (fv) begin
        for (int ch = 0; ch < NCH; ch++) pix_mem[tb_r][tb_c][ch] <= feat[ch];
        if ((tb_r % 2 == 1) && (tb_c % 2 == 1)) begin
          exp_q.push_back(window_max(tb_r, tb_c));
          model_log.push_back(window_max(tb_r, tb_c));
          exp_valid <= 1'b1;
          exp_last  <= (tb_r == H - 1) && (tb_c == W - 1);
        end
        exp_err <= flast && !((tb_r == H - 1) && (tb_c == W - 1));
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic signed [DW-1:0] held_r [0:NCH-1];
  logic signed [DW-1:0] held_n [0:NCH-1];
  vec_t cur;
  int pulse_cnt = 0;
  int last_cnt  = 0;
  int err_cnt   = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int ch = 0; ch < NCH; ch++) begin
        held_r[ch] = '0;
        held_n[ch] = '0;
      end
    end
    chk("valid_relu", v_r, exp_valid);
    chk("valid_raw", v_n, exp_valid);
    chk("last_relu", last_r, exp_last);
    chk("last_raw", last_n, exp_last);
    chk("sync_err_relu", err_r, exp_err);
    chk("sync_err_raw", err_n, exp_err);
    if (v_r === 1'b1) pulse_cnt++;
    if (last_r === 1'b1) last_cnt++;
    if (err_r === 1'b1) begin
      err_cnt++;
      chk("err_col_cleared", dcol_r, 0);
      chk("err_row_cleared", drow_r, 0);
    end
    if (exp_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL exp_q_underflow: got empty queue, expected a window (t=%0t)", $time);
      end else begin
        cur = exp_q.pop_front();
        for (int ch = 0; ch < NCH; ch++) begin
          held_n[ch] = $signed(cur[ch]);
          held_r[ch] = relu($signed(cur[ch]));
        end
      end
    end
    for (int ch = 0; ch < NCH; ch++) begin
      chk($sformatf("pooled_relu[%0d]", ch), pooled_r[ch], held_r[ch]);
      chk($sformatf("pooled_raw[%0d]", ch), pooled_n[ch], held_n[ch]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      fv    = 1'b0;
      flast = 1'b0;
    end
  endtask

  task automatic beat(input int mode, input int r, input int c, input logic last);
    @(posedge clk);
    #1;
    fv    = 1'b1;
    tb_r  = r;
    tb_c  = c;
    flast = last;
    for (int ch = 0; ch < NCH; ch++) feat[ch] = pix_val(mode, r, c, ch);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_valid"}, v_r, 0);
    chk({tag, "_last"}, last_r, 0);
    chk({tag, "_err"}, err_r, 0);
    chk({tag, "_col"}, dcol_r, 0);
    chk({tag, "_row"}, drow_r, 0);
    chk({tag, "_state"}, st_r, 0);
    for (int ch = 0; ch < NCH; ch++) begin
      chk($sformatf("%s_pooled_relu[%0d]", tag, ch), pooled_r[ch], 0);
      chk($sformatf("%s_pooled_raw[%0d]", tag, ch), pooled_n[ch], 0);
    end
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #1;
    fv    = 1'b0;
    flast = 1'b0;
    rst_n = 1'b0;
    #1;
    check_cleared("midrst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // stop_r/stop_c < 0: full frame. Otherwise the frame ends early at that
  // position, either with a misplaced i_last_feature or with a reset pulse.
  task automatic run_frame(input int mode, input int gap_pct, input logic end_last,
                           input int stop_r, input int stop_c, input logic stop_rst);
    logic is_stop;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        is_stop = (r == stop_r) && (c == stop_c);
        if (is_stop && stop_rst) begin
          mid_reset();
          return;
        end
        while ($urandom_range(0, 99) < gap_pct) idle(1);
        beat(mode, r, c, (end_last && r == H - 1 && c == W - 1) || is_stop);
        if (is_stop) begin
          idle(3);
          return;
        end
      end
    end
    idle(3);
  endtask

  // ---------------- test sequence ----------------
  int p0, l0, e0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    fv    = 1'b1;
    flast = 1'b0;
    tb_r  = 0;
    tb_c  = 0;
    for (int ch = 0; ch < NCH; ch++) feat[ch] = DW'($urandom_range(0, 65535));
    #12;
    check_cleared("reset");
    #10;
    fv    = 1'b0;
    rst_n = 1'b1;

    // Ramp: window max is its bottom-right pixel.
    model_log.delete(); p0 = pulse_cnt; l0 = last_cnt;
    run_frame(M_RAMP, 0, 1'b1, -1, -1, 1'b0);
    chk("ramp_model_count", model_log.size(), 196);
    chk("ramp_model_first", $signed(model_log[0][0]), 29);
    chk("ramp_model_last", $signed(model_log[195][0]), 783);
    chk("ramp_pulses", pulse_cnt - p0, 196);
    chk("ramp_last_pulses", last_cnt - l0, 1);
    chk("ramp_final_out", pooled_r[3], 783);

    // Negative constant: ReLU clamps, raw passes through.
    model_log.delete();
    run_frame(M_NEG5, 0, 1'b1, -1, -1, 1'b0);
    chk("neg5_model", $signed(model_log[0][0]), -5);
    chk("neg5_relu_out", pooled_r[0], 0);
    chk("neg5_raw_out", pooled_n[0], -5);

    // Signed extremes and per-channel distinct patterns.
    model_log.delete();
    run_frame(M_EXT, 0, 1'b1, -1, -1, 1'b0);
    chk("ext_model_ch0", $signed(model_log[0][0]), 32767);
    chk("ext_model_ch1", $signed(model_log[0][1]), -32768);
    chk("ext_relu_ch0", pooled_r[0], 32767);
    chk("ext_raw_ch1", pooled_n[1], -32768);
    chk("ext_relu_ch1", pooled_r[1], 0);
    chk("ext_raw_ch2", pooled_n[2], -754);
    chk("ext_raw_ch3", pooled_n[3], 429);

    // Ramp with random valid gaps, frame end without i_last_feature.
    model_log.delete(); p0 = pulse_cnt; l0 = last_cnt; e0 = err_cnt;
    run_frame(M_RAMP, 30, 1'b0, -1, -1, 1'b0);
    chk("gap_model_last", $signed(model_log[195][0]), 783);
    chk("gap_pulses", pulse_cnt - p0, 196);
    chk("gap_last_pulses", last_cnt - l0, 1);
    chk("gap_no_err", err_cnt - e0, 0);

    // Misplaced i_last_feature at (3,10).
    p0 = pulse_cnt; l0 = last_cnt; e0 = err_cnt;
    run_frame(M_RAMP, 0, 1'b0, 3, 10, 1'b0);
    chk("sync_pulses", pulse_cnt - p0, 19);
    chk("sync_no_last", last_cnt - l0, 0);
    chk("sync_err_count", err_cnt - e0, 1);

    model_log.delete(); p0 = pulse_cnt;
    run_frame(M_RAMP, 0, 1'b1, -1, -1, 1'b0);
    chk("after_sync_first", $signed(model_log[0][0]), 29);
    chk("after_sync_pulses", pulse_cnt - p0, 196);

    // Reset asserted mid-frame at (5,7), then a clean frame.
    run_frame(M_RAMP, 0, 1'b1, 5, 7, 1'b1);
    model_log.delete(); p0 = pulse_cnt; l0 = last_cnt;
    run_frame(M_RAMP, 10, 1'b1, -1, -1, 1'b0);
    chk("after_rst_last", $signed(model_log[195][0]), 783);
    chk("after_rst_pulses", pulse_cnt - p0, 196);
    chk("after_rst_last_pulses", last_cnt - l0, 1);

    idle(2);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
